// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO-class funct codes and the mul/div sequencer states.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the four iterative multiply/divide functs
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // True for any instruction that touches HI/LO
  function automatic logic is_hilo(input logic [5:0] f);
    return is_muldiv(f) || (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Multiply: hi accumulates, lo holds the multiplier and collects product low bits.
// Divide:   hi is the partial remainder, lo holds the dividend and collects quotient bits.
module md_iter_core #(
  parameter int unsigned W = mips_pkg::XLEN
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] m,
  output logic [W-1:0] hi_nxt,
  output logic [W-1:0] lo_nxt
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  // Single accumulator step; a borrow in diff[W] means the trial subtract failed
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(W+1){1'b0}});
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      if (!diff[W]) begin
        hi_nxt = diff[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_controller.sv
// Sequences the iterative mul/div datapath, owns HI/LO and raises the EX-stage stall.
module mul_div_controller #(
  parameter int unsigned XLEN  = mips_pkg::XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            div_by_zero_o,
  output logic [XLEN-1:0] mf_data_o
);

  import mips_pkg::*;

  localparam int unsigned PW = 2 * XLEN;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  hi_q, lo_q;
  logic [XLEN-1:0]  acc_hi_q, acc_lo_q, m_q, rs_q;
  logic [XLEN-1:0]  core_hi, core_lo;
  logic             is_div_q, neg_q_q, neg_r_q;
  logic             accept, mt_write, busy_d, done_d, dbz_d;
  logic             op_signed, op_div, rs_neg, rt_neg;
  logic [XLEN-1:0]  rs_abs, rt_abs;
  logic [PW-1:0]    prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  md_iter_core #(.W(XLEN)) u_core (
    .is_div (is_div_q),
    .hi     (acc_hi_q),
    .lo     (acc_lo_q),
    .m      (m_q),
    .hi_nxt (core_hi),
    .lo_nxt (core_lo)
  );

  // Operand conditioning: magnitudes for the unsigned core plus result sign flags
  always_comb begin
    op_signed = (funct_i == F_MULT) || (funct_i == F_DIV);
    op_div    = (funct_i == F_DIV)  || (funct_i == F_DIVU);
    rs_neg    = op_signed & rs_val_i[XLEN-1];
    rt_neg    = op_signed & rt_val_i[XLEN-1];
    rs_abs    = rs_neg ? ('0 - rs_val_i) : rs_val_i;
    rt_abs    = rt_neg ? ('0 - rt_val_i) : rt_val_i;
  end

  // Sign fix-up of the raw core result, applied as HI/LO are committed
  always_comb begin
    prod_fix = neg_q_q ? (PW'(0) - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    quo_fix  = neg_q_q ? ('0 - acc_lo_q) : acc_lo_q;
    rem_fix  = neg_r_q ? ('0 - acc_hi_q) : acc_hi_q;
  end

  // Next-state and registered-output decode; flush overrides everything
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mt_write = 1'b0;
    done_d   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && is_muldiv(funct_i)) begin
            accept  = 1'b1;
            state_d = RUN;
          end else if (start_i && ((funct_i == F_MTHI) || (funct_i == F_MTLO))) begin
            mt_write = 1'b1;
          end
        end
        RUN: begin
          if (count_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    dbz_d  = done_d & is_div_q & (m_q == '0);
  end

  // State register, iteration counter and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      div_by_zero_o <= dbz_d;
      if (accept || flush_i) count_q <= '0;
      else if (state_q == RUN) count_q <= count_q + CNT_W'(1);
    end
  end

  // Working accumulator, operand latches and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      rs_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        acc_hi_q <= '0;
        acc_lo_q <= op_div ? rs_abs : rt_abs;
        m_q      <= op_div ? rt_abs : rs_abs;
        rs_q     <= rs_val_i;
        is_div_q <= op_div;
        neg_q_q  <= rs_neg ^ rt_neg;
        neg_r_q  <= rs_neg;
      end else if ((state_q == RUN) && !flush_i) begin
        acc_hi_q <= core_hi;
        acc_lo_q <= core_lo;
      end

      if (mt_write) begin
        if (funct_i == F_MTHI) hi_q <= rs_val_i;
        else                   lo_q <= rs_val_i;
      end else if (done_d) begin
        if (!is_div_q) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (m_q == '0) begin
          hi_q <= rs_q;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  // Move-from read port and hazard stall are combinational
  assign mf_data_o = (funct_i == F_MFHI) ? hi_q : lo_q;
  assign stall_o   = start_i & busy_o & is_hilo(funct_i) & ~flush_i;

endmodule
